// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and latch-enable controller for a five-stage pipeline.
//               Turns cache-wait, stall, flush and halt requests into per-latch
//               enables (en_*) and bubble inserts (clr_*). Flush requests that
//               arrive while the data cache freezes the pipe are held and
//               applied on the first unfrozen cycle.
//
// Ports       : CLK          rising-edge clock
//               RST          synchronous reset, active-high
//               stall        load-use stall request
//               flush_ifid   flush request for the IF/ID latch
//               flush_idex   flush request for the ID/EX latch
//               flush_exmem  flush request for the EX/MEM latch
//               ihit         instruction cache hit
//               dhit         data cache hit
//               mem_req      MEM stage issues a data read or write
//               halt_wb      halt instruction valid in WB
//               en_pc, en_ifid, en_idex, en_exmem, en_memwb   latch enables
//               clr_ifid, clr_idex, clr_exmem                 bubble inserts
//               halt         sticky halt, cleared only by RST
//               freeze_cnt   cycles frozen by a data-cache wait
//               flush_cnt    cycles in which a flush was applied
//
// Options     : PIPE_PERF_CNT_EN  when defined, freeze_cnt / flush_cnt are
//               saturating 16-bit counters; otherwise both read as zero and
//               no counter flops exist.
//
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        flush_ifid,
    input  logic        flush_idex,
    input  logic        flush_exmem,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic        halt_wb,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        en_memwb,
    output logic        clr_ifid,
    output logic        clr_idex,
    output logic        clr_exmem,
    output logic        halt,
    output logic [15:0] freeze_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_PEND = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    // Flush vectors: bit 0 = IF/ID, bit 1 = ID/EX, bit 2 = EX/MEM.
    localparam logic [2:0] c_FLUSH_IDEX_ONLY = 3'b010;

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_state_eff;
    logic [2:0] r_pending;
    logic [2:0] w_pending_next;
    logic [2:0] w_pending_eff;
    logic [2:0] w_flush_live;
    logic [2:0] w_flush_apply;
    logic       w_dwait;
    logic       w_iwait;
    logic       w_load_use;
    logic       w_apply;

    assign w_dwait      = mem_req & ~dhit;
    assign w_iwait      = ~ihit;
    assign w_flush_live = {flush_exmem, flush_idex, flush_ifid};

    // While RST is held the outputs behave as in RUN with nothing pending,
    // whatever the registered state currently is.
    assign w_state_eff   = RST ? ST_RUN : r_state;
    assign w_pending_eff = RST ? 3'b000 : r_pending;

    assign w_flush_apply = w_pending_eff | w_flush_live;

    // A load-use hazard arrives as stall plus an ID/EX flush. The stall path
    // already bubbles ID/EX while holding PC and IF/ID, so that combination
    // is not treated as a redirecting flush (which would advance the PC).
    assign w_load_use = (w_state_eff == ST_RUN) && stall &&
                        (w_flush_live == c_FLUSH_IDEX_ONLY);

    assign w_apply = ~w_dwait && (|w_flush_apply) && ~w_load_use;

    // ------------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        en_pc          = 1'b0;
        en_ifid        = 1'b0;
        en_idex        = 1'b0;
        en_exmem       = 1'b0;
        en_memwb       = 1'b0;
        clr_ifid       = 1'b0;
        clr_idex       = 1'b0;
        clr_exmem      = 1'b0;
        w_state_next   = w_state_eff;
        w_pending_next = w_pending_eff;

        if (w_state_eff == ST_HALTED) begin
            w_state_next = ST_HALTED;
        end else if (w_dwait) begin
            // Frozen: every latch holds, but flush requests are remembered.
            if (|w_flush_live) begin
                w_pending_next = w_pending_eff | w_flush_live;
                w_state_next   = ST_FLUSH_PEND;
            end
        end else begin
            if (w_apply) begin
                // Redirect: PC loads the target, flushed latches take bubbles.
                en_pc          = 1'b1;
                en_ifid        = 1'b1;
                en_idex        = 1'b1;
                en_exmem       = 1'b1;
                en_memwb       = 1'b1;
                clr_ifid       = w_flush_apply[0];
                clr_idex       = w_flush_apply[1];
                clr_exmem      = w_flush_apply[2];
                w_pending_next = 3'b000;
                w_state_next   = ST_RUN;
            end else if (stall) begin
                en_idex  = 1'b1;
                clr_idex = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end else if (w_iwait) begin
                en_ifid  = 1'b1;
                clr_ifid = 1'b1;
                en_idex  = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end else begin
                en_pc    = 1'b1;
                en_ifid  = 1'b1;
                en_idex  = 1'b1;
                en_exmem = 1'b1;
                en_memwb = 1'b1;
            end

            // The halt only retires once MEM/WB actually advances.
            if (halt_wb && en_memwb) begin
                w_state_next = ST_HALTED;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and pending-flush registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_RUN;
            r_pending <= 3'b000;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    assign halt = (r_state == ST_HALTED);

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_freeze_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_freeze_evt;

    assign w_freeze_evt = w_dwait && (w_state_eff != ST_HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_freeze_cnt <= 16'd0;
            r_flush_cnt  <= 16'd0;
        end else begin
            if (w_freeze_evt && (r_freeze_cnt != 16'hFFFF)) begin
                r_freeze_cnt <= r_freeze_cnt + 16'd1;
            end
            // An applied flush always carries at least one clr_* bit.
            if (w_apply && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign freeze_cnt = r_freeze_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign freeze_cnt = 16'd0;
    assign flush_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Each scenario task
//               drives one input vector per cycle, pushes the expected output
//               vector to a scoreboard queue, and pops/compares it mid-cycle.
//               A small counter model tracks expected freeze/flush counts.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    // Input vector bits: {RST, stall, flush_ifid, flush_idex, flush_exmem,
    //                     ihit, dhit, mem_req, halt_wb}
    localparam logic [8:0] I_RST   = 9'h100;
    localparam logic [8:0] I_STALL = 9'h080;
    localparam logic [8:0] I_FI    = 9'h040;
    localparam logic [8:0] I_FD    = 9'h020;
    localparam logic [8:0] I_FE    = 9'h010;
    localparam logic [8:0] I_IHIT  = 9'h008;
    localparam logic [8:0] I_DHIT  = 9'h004;
    localparam logic [8:0] I_MREQ  = 9'h002;
    localparam logic [8:0] I_HWB   = 9'h001;

    // Output vector bits: {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
    //                      clr_ifid, clr_idex, clr_exmem, halt}
    localparam logic [8:0] O_RUN   = 9'b11111_000_0;
    localparam logic [8:0] O_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] O_STALL = 9'b00111_010_0;
    localparam logic [8:0] O_IWAIT = 9'b01111_100_0;
    localparam logic [8:0] O_HALT  = 9'b00000_000_1;
    localparam logic [8:0] C_IFID  = 9'b00000_100_0;
    localparam logic [8:0] C_IDEX  = 9'b00000_010_0;
    localparam logic [8:0] C_EXMEM = 9'b00000_001_0;
    localparam logic [8:0] O_HBIT  = 9'b00000_000_1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, flush_ifid, flush_idex, flush_exmem;
    logic        ihit, dhit, mem_req, halt_wb;
    logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic        clr_ifid, clr_idex, clr_exmem, halt;
    logic [15:0] freeze_cnt, flush_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] m_freeze = 16'd0;
    logic [15:0] m_flush  = 16'd0;
    logic [8:0]  w_obs;

    always #5 CLK = ~CLK;

    assign w_obs = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                    clr_ifid, clr_idex, clr_exmem, halt};

    pipeline_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .stall      (stall),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .flush_exmem(flush_exmem),
        .ihit       (ihit),
        .dhit       (dhit),
        .mem_req    (mem_req),
        .halt_wb    (halt_wb),
        .en_pc      (en_pc),
        .en_ifid    (en_ifid),
        .en_idex    (en_idex),
        .en_exmem   (en_exmem),
        .en_memwb   (en_memwb),
        .clr_ifid   (clr_ifid),
        .clr_idex   (clr_idex),
        .clr_exmem  (clr_exmem),
        .halt       (halt),
        .freeze_cnt (freeze_cnt),
        .flush_cnt  (flush_cnt)
    );

    // Drive one input vector and record the output expected for it.
    task automatic drive(input logic [8:0] in, input logic [8:0] exp);
        {RST, stall, flush_ifid, flush_idex, flush_exmem,
         ihit, dhit, mem_req, halt_wb} = in;
        exp_q.push_back(exp);
    endtask

    // Close the cycle and advance the counter model from the row's meaning.
    task automatic end_cycle(input logic [8:0] in, input logic [8:0] exp);
        @(posedge CLK);
        if (in[8]) begin
            m_freeze = 16'd0;
            m_flush  = 16'd0;
        end else begin
`ifdef PIPE_PERF_CNT_EN
            if (in[1] && !in[2] && !exp[0] && m_freeze != 16'hFFFF)
                m_freeze = m_freeze + 16'd1;
            if (exp[8:4] == 5'b11111 && exp[3:1] != 3'b000 && m_flush != 16'hFFFF)
                m_flush = m_flush + 16'd1;
`endif
        end
        #1;
    endtask

    task automatic test_reset;
        logic [17:0] tbl [3] = '{
            {I_RST | I_IHIT,           O_RUN},
            {I_RST | I_STALL | I_IHIT, O_STALL},
            {I_IHIT,                   O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL reset[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL reset[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_run_modes;
        logic [17:0] tbl [8] = '{
            {I_IHIT,                    O_RUN},
            {9'h000,                    O_IWAIT},
            {I_STALL | I_IHIT,          O_STALL},
            {I_STALL,                   O_STALL},
            {I_IHIT | I_MREQ | I_DHIT,  O_RUN},
            {I_IHIT | I_MREQ | I_STALL, O_FRZ},
            {I_MREQ,                    O_FRZ},
            {I_IHIT,                    O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL run_modes[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL run_modes[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_freeze_flush;
        logic [17:0] tbl [10] = '{
            {I_RST | I_IHIT,                  O_RUN},
            {I_IHIT | I_MREQ | I_FI | I_FD,   O_FRZ},
            {I_IHIT | I_MREQ,                 O_FRZ},
            {I_IHIT | I_MREQ,                 O_FRZ},
            {I_IHIT | I_MREQ | I_DHIT,        O_RUN | C_IFID | C_IDEX},
            {I_IHIT,                          O_RUN},
            {I_IHIT | I_MREQ | I_FI,          O_FRZ},
            {I_IHIT | I_MREQ | I_FE,          O_FRZ},
            {I_STALL | I_FD | I_MREQ | I_DHIT, O_RUN | C_IFID | C_IDEX | C_EXMEM},
            {I_IHIT,                          O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL freeze_flush[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL freeze_flush[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_load_use_branch;
        logic [17:0] tbl [4] = '{
            {I_STALL | I_FD | I_IHIT,  O_STALL},
            {I_FI | I_FD | I_FE,       O_RUN | C_IFID | C_IDEX | C_EXMEM},
            {I_FI | I_STALL | I_IHIT,  O_RUN | C_IFID},
            {I_IHIT,                   O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL load_use_branch[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL load_use_branch[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_halt;
        logic [17:0] tbl [16] = '{
            {I_RST | I_IHIT,                          O_RUN},
            {I_IHIT,                                  O_RUN},
            {I_IHIT,                                  O_RUN},
            {I_IHIT,                                  O_RUN},
            {I_IHIT | I_HWB,                          O_RUN},
            {I_IHIT,                                  O_HALT},
            {I_STALL | I_FI | I_MREQ,                 O_HALT},
            {I_FD | I_FE | I_DHIT | I_MREQ | I_HWB,   O_HALT},
            {I_IHIT,                                  O_HALT},
            {I_RST | I_IHIT,                          O_RUN | O_HBIT},
            {I_IHIT,                                  O_RUN},
            {I_IHIT | I_MREQ | I_HWB,                 O_FRZ},
            {I_IHIT | I_MREQ | I_DHIT | I_HWB,        O_RUN},
            {I_IHIT,                                  O_HALT},
            {I_RST | I_IHIT,                          O_RUN | O_HBIT},
            {I_IHIT,                                  O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL halt[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL halt[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_reset_pending;
        logic [17:0] tbl [4] = '{
            {I_IHIT | I_MREQ | I_FI | I_FE, O_FRZ},
            {I_RST | I_IHIT,                O_RUN},
            {I_IHIT | I_MREQ | I_DHIT,      O_RUN},
            {I_IHIT,                        O_RUN}
        };
        logic [8:0] got;
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i][17:9], tbl[i][8:0]);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                $display("FAIL reset_pending[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            n_checks++;
            if (freeze_cnt !== m_freeze || flush_cnt !== m_flush) begin
                n_fail++;
                $display("FAIL reset_pending[%0d] counters: got %0d/%0d expected %0d/%0d",
                         i, freeze_cnt, flush_cnt, m_freeze, m_flush);
            end
            end_cycle(tbl[i][17:9], tbl[i][8:0]);
        end
    endtask

    task automatic test_saturation;
        logic [8:0]  got;
        logic [8:0]  in;
        logic [8:0]  exp;
        logic [15:0] sat_exp;
        int          n_bad = 0;
`ifdef PIPE_PERF_CNT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'h0000;
`endif
        for (int i = 0; i < 65542; i++) begin
            if (i == 0) begin
                in = I_RST | I_IHIT;  exp = O_RUN;
            end else if (i == 65541) begin
                in = I_IHIT;          exp = O_RUN;
            end else begin
                in = I_IHIT | I_MREQ; exp = O_FRZ;
            end
            drive(in, exp);
            @(negedge CLK);
            got = exp_q.pop_front();
            n_checks++;
            if (w_obs !== got) begin
                n_fail++;
                n_bad++;
                if (n_bad < 5)
                    $display("FAIL saturation[%0d] outputs: got %b expected %b", i, w_obs, got);
            end
            end_cycle(in, exp);
        end
        @(negedge CLK);
        n_checks++;
        if (freeze_cnt !== sat_exp || freeze_cnt !== m_freeze) begin
            n_fail++;
            $display("FAIL saturation freeze_cnt: got %h expected %h", freeze_cnt, sat_exp);
        end
        n_checks++;
        if (flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL saturation flush_cnt: got %h expected 0000", flush_cnt);
        end
    endtask

    initial begin
        {RST, stall, flush_ifid, flush_idex, flush_exmem,
         ihit, dhit, mem_req, halt_wb} = I_RST | I_IHIT;
        @(posedge CLK);
        #1;
        test_reset();
        test_run_modes();
        test_freeze_flush();
        test_load_use_branch();
        test_halt();
        test_reset_pending();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
